imem_boot_loader: RTL

- Writer side of the processor's instruction-memory interface. The core only reads instruction memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake, parses a framed program image and assembles 16-bit instruction words.
- Writes each word into instruction memory at the byte address the PC will fetch.
- Holds the CPU in reset until a complete image with a correct checksum has been loaded.

---
 rtl/imem_boot_loader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Fills instruction memory from a framed byte stream and holds the CPU in
//   reset until a complete image with a matching XOR checksum has arrived.
//   Frame: SYNC_BYTE, LEN_HI, LEN_LO, 2*LEN data bytes (high byte first), CHK.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   rx_valid    byte source has a byte
//   rx_data     byte data
//   rx_ready    loader accepts a byte this cycle (registered)
//   imem_we     one-cycle write strobe per assembled word
//   imem_addr   byte address of the write ({word_index,1'b0})
//   imem_wdata  assembled 16-bit instruction word
//   cpu_reset   processor reset, high until a verified load completes
//   load_done   image loaded and checksum verified (sticky)
//   load_error  frame rejected (cleared by the next SYNC_BYTE)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SYNC     | hunting for SYNC_BYTE, other bytes discarded
// LEN_HI   | next byte is word count [15:8]
// LEN_LO   | next byte is word count [7:0], length checked here
// DATA_HI  | next byte is the high half of a word
// DATA_LO  | next byte is the low half, completes a word write
// CHECK    | next byte is the XOR checksum of all data bytes
// DONE     | image verified, CPU released, stream closed
// ERROR    | frame rejected, draining until a new SYNC_BYTE

module imem_boot_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [15:0] imem_wdata,
  output logic        cpu_reset,
  output logic        load_done,
  output logic        load_error
);

  localparam logic [2:0] S_SYNC    = 3'd0;
  localparam logic [2:0] S_LEN_HI  = 3'd1;
  localparam logic [2:0] S_LEN_LO  = 3'd2;
  localparam logic [2:0] S_DATA_HI = 3'd3;
  localparam logic [2:0] S_DATA_LO = 3'd4;
  localparam logic [2:0] S_CHECK   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;
  localparam logic [2:0] S_ERROR   = 3'd7;

  // 17 bits so that a full 2^16-word memory still compares correctly.
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  logic [2:0]        state;
  logic [15:0]       count;
  logic [ADDR_W-1:0] index;
  logic [7:0]        checksum;
  logic [7:0]        hi_byte;

  logic        accept;
  logic [15:0] len_next;
  logic [16:0] index_ext;
  logic [16:0] last_word;

  assign accept    = rx_valid & rx_ready;
  assign len_next  = {count[15:8], rx_data};
  assign index_ext = 17'(index);
  // Only used in DATA_LO, where count is known to be non-zero.
  assign last_word = {1'b0, count} - 17'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_SYNC;
      rx_ready   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= 16'h0000;
      imem_wdata <= 16'h0000;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      count      <= 16'h0000;
      index      <= '0;
      checksum   <= 8'h00;
      hi_byte    <= 8'h00;
    end else begin
      imem_we <= 1'b0;
      if (accept) begin
        case (state)
          S_SYNC: begin
            if (rx_data == SYNC_BYTE) state <= S_LEN_HI;
          end
          S_LEN_HI: begin
            count[15:8] <= rx_data;
            state       <= S_LEN_LO;
          end
          S_LEN_LO: begin
            count[7:0] <= rx_data;
            if ({1'b0, len_next} > MAX_WORDS) begin
              state      <= S_ERROR;
              load_error <= 1'b1;
            end else if (len_next == 16'h0000) begin
              state <= S_CHECK;
            end else begin
              state <= S_DATA_HI;
            end
          end
          S_DATA_HI: begin
            hi_byte  <= rx_data;
            checksum <= checksum ^ rx_data;
            state    <= S_DATA_LO;
          end
          S_DATA_LO: begin
            checksum   <= checksum ^ rx_data;
            imem_we    <= 1'b1;
            imem_wdata <= {hi_byte, rx_data};
            imem_addr  <= 16'({index, 1'b0});
            index      <= index + 1'b1;
            state      <= (index_ext == last_word) ? S_CHECK : S_DATA_HI;
          end
          S_CHECK: begin
            if (rx_data == checksum) begin
              state     <= S_DONE;
              rx_ready  <= 1'b0;
              load_done <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state      <= S_ERROR;
              load_error <= 1'b1;
            end
          end
          S_ERROR: begin
            // Restart on a new frame; memory already written is left intact.
            if (rx_data == SYNC_BYTE) begin
              load_error <= 1'b0;
              count      <= 16'h0000;
              index      <= '0;
              checksum   <= 8'h00;
              state      <= S_LEN_HI;
            end
          end
          default: begin
            // DONE never accepts (rx_ready is low there).
            state <= state;
          end
        endcase
      end
    end
  end

endmodule
